// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch bridge.
//   fetch_state_e : controller state encoding (also exported on the debug port)
//   fetch_step()  : byte distance between consecutive instruction words
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_STREAM = 2'd2
  } fetch_state_e;

  localparam int FETCH_DEFAULT_DATA_W = 32;

  // One instruction word occupies DATA_W/8 bytes of address space.
  function automatic int fetch_step(input int data_w);
    return data_w / 8;
  endfunction

  localparam int FETCH_STEP = fetch_step(FETCH_DEFAULT_DATA_W);

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH x DATA_W circular FIFO with synchronous flush.
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_push, i_data      write one word at the tail
//   i_pop               drop the head word (o_data shows it this cycle)
//   i_flush             empty the buffer; wins over push and pop
//   o_data              head word (meaningful only while !o_empty)
//   o_count, o_empty    occupancy
module fetch_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [DATA_W-1:0]          o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  // Guards make a stray push/pop harmless; the bridge never requests them.
  assign w_push  = i_push & ~w_full & ~i_flush;
  assign w_pop   = i_pop & ~o_empty & ~i_flush;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage needs no reset: a word is only read after it has been written.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: sequential prefetcher between a CPU fetch port
// and a pipelined read-only memory with in-order returns of unbounded latency.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   cpu_ce_i/addr_i     CPU fetch request (address held while stalled)
//   cpu_inst_o/valid_o  instruction delivered combinationally on a buffer hit
//   cpu_stall_o         request present but not satisfied this cycle
//   mem_ce_o/addr_o     one read issue per cycle, address held when idle
//   mem_rvalid_i/rdata_i read returns, in issue order
//   dbg_state_o         controller state (fetch_state_e encoding)
//
// Handshake: a request is "accepted" in any cycle where cpu_ce_i=1 and
// cpu_valid_o=1; the CPU must hold cpu_addr_i while cpu_stall_o=1. The memory
// side has no back-pressure: every mem_ce_o=1 cycle is an issued read, and
// every mem_rvalid_i=1 cycle returns exactly one earlier read.
module inst_fetch_bridge
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic [DATA_W-1:0] cpu_inst_o,
  output logic              cpu_valid_o,
  output logic              cpu_stall_o,
  output logic              mem_ce_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [1:0]        dbg_state_o
);

  localparam int STEP = fetch_step(DATA_W);
  localparam int LSB  = $clog2(STEP);
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  fetch_state_e r_state;
  fetch_state_e w_next_state;

  logic [ADDR_W-1:0] r_head_addr;   // address of the buffer head word
  logic [ADDR_W-1:0] r_fetch_addr;  // next address to issue
  logic [ADDR_W-1:0] r_last_addr;   // last issued address, shown while idle
  logic [CW-1:0]     r_outstanding; // reads issued but not yet returned
  logic [CW-1:0]     r_discard;     // in-flight reads belonging to a dead stream

  logic              w_ce;
  logic              w_match;
  logic              w_hit;
  logic              w_miss;
  logic              w_credit;
  logic              w_issue;
  logic              w_ret;
  logic              w_drop;
  logic              w_push;
  logic [CW-1:0]     w_out_next;
  logic [CW-1:0]     w_count;
  logic              w_empty;
  logic [DATA_W-1:0] w_head_data;

  // Keeping the request gated by reset forces every output low while rst=0.
  assign w_ce    = cpu_ce_i & rst;
  // Sub-word address bits do not select a different instruction.
  assign w_match = (cpu_addr_i[ADDR_W-1:LSB] == r_head_addr[ADDR_W-1:LSB]);
  assign w_hit   = w_ce & ~w_empty & w_match;
  // A mismatch is a miss even with an empty buffer; an empty buffer with a
  // matching address just waits for the word already in flight.
  assign w_miss  = w_ce & ~w_match;

  // Buffered plus in-flight words (discarded ones included) may never exceed
  // DEPTH, so a returning word always has a free slot.
  assign w_credit = (({1'b0, w_count} + {1'b0, r_outstanding}) < DEPTH_L);
  assign w_issue  = (r_state != ST_IDLE) & ~w_miss & w_credit;

  // Returns with nothing outstanding (stragglers across a reset) are ignored.
  assign w_ret  = mem_rvalid_i & (r_outstanding != '0);
  assign w_drop = w_ret & (r_discard != '0);
  assign w_push = w_ret & (r_discard == '0) & ~w_miss;

  assign w_out_next = r_outstanding + CW'(w_issue) - CW'(w_ret);

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_push  (w_push),
    .i_data  (mem_rdata_i),
    .i_pop   (w_hit),
    .i_flush (w_miss),
    .o_data  (w_head_data),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  assign cpu_valid_o = w_hit;
  assign cpu_inst_o  = w_hit ? w_head_data : '0;
  assign cpu_stall_o = w_ce & ~w_hit;
  assign mem_ce_o    = w_issue;
  assign mem_addr_o  = w_issue ? r_fetch_addr : r_last_addr;
  assign dbg_state_o = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (!w_ce) begin
      w_next_state = ST_IDLE;
    end else if (w_miss) begin
      w_next_state = ST_REFILL;
    end else begin
      unique case (r_state)
        // Resuming at the retained head: stream if words are already here,
        // otherwise restart issuing from fetch_addr.
        ST_IDLE:   w_next_state = (!w_empty || w_push) ? ST_STREAM : ST_REFILL;
        ST_REFILL: if (w_push) w_next_state = ST_STREAM;
        ST_STREAM: w_next_state = ST_STREAM;
        default:   w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head_addr   <= '0;
      r_fetch_addr  <= '0;
      r_last_addr   <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (w_miss) begin
        r_head_addr  <= cpu_addr_i;
        r_fetch_addr <= cpu_addr_i;
        // Everything still in flight after this edge belongs to the old stream.
        r_discard    <= w_out_next;
      end else begin
        if (w_hit)   r_head_addr  <= r_head_addr + ADDR_W'(STEP);
        if (w_issue) r_fetch_addr <= r_fetch_addr + ADDR_W'(STEP);
        if (w_drop)  r_discard    <= r_discard - CW'(1);
      end
      if (w_issue) r_last_addr <= r_fetch_addr;
    end
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
module tb_inst_fetch_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_ce_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic [31:0] cpu_inst_o;
  logic        cpu_valid_o;
  logic        cpu_stall_o;
  logic        mem_ce_o;
  logic [31:0] mem_addr_o;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic [1:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int lat    = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rd_t;
  rd_t         rd_q[$];
  logic [31:0] issue_log[$];
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inst_fetch_bridge #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_ce_i     (cpu_ce_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_inst_o   (cpu_inst_o),
    .cpu_valid_o  (cpu_valid_o),
    .cpu_stall_o  (cpu_stall_o),
    .mem_ce_o     (mem_ce_o),
    .mem_addr_o   (mem_addr_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .dbg_state_o  (dbg_state)
  );

  // Memory contents: each word is a fixed scramble of its own address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory responder: returns each read exactly lat cycles after issue and is
  // reset together with the bridge.
  always @(negedge clk) begin
    if (!rst) begin
      rd_q.delete();
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem_word(rd_q[0].addr);
        void'(rd_q.pop_front());
      end
      if (mem_ce_o) begin
        rd_q.push_back('{addr: mem_addr_o, due: cyc + lat});
        issue_log.push_back(mem_addr_o);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int l);
    @(posedge clk); #1;
    rst = 1'b0; cpu_ce_i = 1'b0; cpu_addr_i = '0; lat = l;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    issue_log.delete();
  endtask

  // Sequential CPU: requests cur, advances on each delivery, stops once stop
  // becomes the next request.
  task automatic run_stream(input logic [31:0] start, input logic [31:0] stop,
                            input int budget, input string name);
    logic [31:0] cur;
    bit          done;
    cur = start;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk); #1;
      cpu_ce_i = 1'b1; cpu_addr_i = cur;
      @(negedge clk); #1;
      n_cmp++;
      if (cpu_stall_o !== ~cpu_valid_o) begin
        n_fail++;
        $display("FAIL %s_stall addr=%h got=%b want=%b", name, cur, cpu_stall_o, ~cpu_valid_o);
      end
      n_cmp++;
      if (cpu_valid_o) begin
        if (cpu_inst_o !== mem_word(cur)) begin
          n_fail++;
          $display("FAIL %s_inst addr=%h got=%h want=%h", name, cur, cpu_inst_o, mem_word(cur));
        end
        cur = cur + 32'd4;
        if (cur == stop) done = 1'b1;
      end else if (cpu_inst_o !== 32'h0) begin
        n_fail++;
        $display("FAIL %s_inst_idle addr=%h got=%h want=0", name, cur, cpu_inst_o);
      end
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout reached=%h want=%h", name, cur, stop);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    @(posedge clk); #1;
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h100;
    @(negedge clk); #1;
    n_cmp++; if (cpu_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b want=0", cpu_valid_o); end
    n_cmp++; if (cpu_stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall got=%b want=0", cpu_stall_o); end
    n_cmp++; if (cpu_inst_o !== 32'h0) begin n_fail++; $display("FAIL rst_inst got=%h want=0", cpu_inst_o); end
    n_cmp++; if (mem_ce_o !== 1'b0) begin n_fail++; $display("FAIL rst_mem_ce got=%b want=0", mem_ce_o); end
    n_cmp++; if (mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr got=%h want=0", mem_addr_o); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_state got=%0d want=0", dbg_state); end
  endtask

  // Latency 1 from 0x100: miss cycle, issue cycle, return cycle, then valid.
  task automatic test_sequential;
    logic [31:0] cur;
    do_reset(1);
    cur = 32'h100;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      cpu_ce_i = 1'b1; cpu_addr_i = cur;
      @(negedge clk); #1;
      n_cmp++;
      if (cpu_valid_o !== (c >= 3)) begin
        n_fail++; $display("FAIL seq_valid c=%0d got=%b want=%b", c, cpu_valid_o, (c >= 3));
      end
      n_cmp++;
      if (cpu_stall_o !== (c < 3)) begin
        n_fail++; $display("FAIL seq_stall c=%0d got=%b want=%b", c, cpu_stall_o, (c < 3));
      end
      if (c >= 3) begin
        n_cmp++;
        if (cpu_inst_o !== mem_word(32'h100 + 32'(4 * (c - 3)))) begin
          n_fail++; $display("FAIL seq_inst c=%0d got=%h want=%h", c, cpu_inst_o, mem_word(32'h100 + 32'(4 * (c - 3))));
        end
      end
      n_cmp++;
      if (mem_ce_o !== (c >= 1)) begin
        n_fail++; $display("FAIL seq_mem_ce c=%0d got=%b want=%b", c, mem_ce_o, (c >= 1));
      end
      if (c >= 1) begin
        n_cmp++;
        if (mem_addr_o !== 32'h100 + 32'(4 * (c - 1))) begin
          n_fail++; $display("FAIL seq_mem_addr c=%0d got=%h want=%h", c, mem_addr_o, 32'h100 + 32'(4 * (c - 1)));
        end
      end
      if (cpu_valid_o) cur = cur + 32'd4;
    end
    n_cmp++;
    if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL seq_state got=%0d want=2", dbg_state); end
  endtask

  // Latency 3: after 0x100,0x104 the CPU jumps to 0x400.
  task automatic test_branch;
    logic [31:0] cur;
    do_reset(3);
    run_stream(32'h100, 32'h108, 30, "br_pre");
    cur = 32'h400;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      cpu_ce_i = 1'b1; cpu_addr_i = cur;
      @(negedge clk); #1;
      n_cmp++;
      if (cpu_valid_o !== (k >= 5)) begin
        n_fail++; $display("FAIL br_valid k=%0d got=%b want=%b", k, cpu_valid_o, (k >= 5));
      end
      n_cmp++;
      if (cpu_inst_o !== ((k >= 5) ? mem_word(cur) : 32'h0)) begin
        n_fail++; $display("FAIL br_inst k=%0d got=%h want=%h", k, cpu_inst_o, (k >= 5) ? mem_word(cur) : 32'h0);
      end
      if (k == 0) begin
        n_cmp++;
        if (mem_ce_o !== 1'b0) begin n_fail++; $display("FAIL br_miss_issue got=%b want=0", mem_ce_o); end
      end
      if (k == 1) begin
        n_cmp++;
        if (mem_ce_o !== 1'b1 || mem_addr_o !== 32'h400) begin
          n_fail++; $display("FAIL br_first_issue ce=%b addr=%h want ce=1 addr=400", mem_ce_o, mem_addr_o);
        end
      end
      if (cpu_valid_o) cur = cur + 32'd4;
    end
    run_stream(cur, cur + 32'd12, 30, "br_post");
  endtask

  // Latency 5: four reads in flight saturate the credit.
  task automatic test_credit;
    logic [31:0] cur;
    int          max_out;
    bit          exp_ce [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    bit          exp_v  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] exp_ma [9] = '{32'h0, 32'h200, 32'h204, 32'h208, 32'h20C,
                                32'h20C, 32'h20C, 32'h20C, 32'h210};
    do_reset(5);
    cur = 32'h200;
    max_out = 0;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      cpu_ce_i = 1'b1; cpu_addr_i = cur;
      @(negedge clk); #1;
      if (rd_q.size() > max_out) max_out = rd_q.size();
      n_cmp++;
      if (mem_ce_o !== exp_ce[c]) begin
        n_fail++; $display("FAIL cr_mem_ce c=%0d got=%b want=%b", c, mem_ce_o, exp_ce[c]);
      end
      n_cmp++;
      if (mem_addr_o !== exp_ma[c]) begin
        n_fail++; $display("FAIL cr_mem_addr c=%0d got=%h want=%h", c, mem_addr_o, exp_ma[c]);
      end
      n_cmp++;
      if (cpu_valid_o !== exp_v[c] || cpu_stall_o !== ~exp_v[c]) begin
        n_fail++; $display("FAIL cr_valid c=%0d valid=%b stall=%b want valid=%b", c, cpu_valid_o, cpu_stall_o, exp_v[c]);
      end
      if (exp_v[c]) begin
        n_cmp++;
        if (cpu_inst_o !== mem_word(cur)) begin
          n_fail++; $display("FAIL cr_inst c=%0d got=%h want=%h", c, cpu_inst_o, mem_word(cur));
        end
      end
      if (cpu_valid_o) cur = cur + 32'd4;
    end
    run_stream(cur, cur + 32'd16, 60, "cr_run");
    n_cmp++;
    if (max_out > 4) begin n_fail++; $display("FAIL cr_outstanding got=%0d want<=4", max_out); end
  endtask

  // Sequential fetch across the top of the address space.
  task automatic test_wrap;
    logic [31:0] got;
    do_reset(1);
    run_stream(32'hFFFF_FFF8, 32'h0000_0004, 20, "wrap");
    exp_q.delete();
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    while (exp_q.size() > 0) begin
      got = (issue_log.size() > 0) ? issue_log.pop_front() : 32'hDEAD_BEEF;
      n_cmp++;
      if (got !== exp_q[0]) begin
        n_fail++; $display("FAIL wrap_issue got=%h want=%h", got, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  // CPU pauses three cycles, then resumes at the retained head.
  task automatic test_pause;
    do_reset(1);
    run_stream(32'h300, 32'h308, 20, "pz_pre");
    for (int p = 0; p < 3; p++) begin
      @(posedge clk); #1;
      cpu_ce_i = 1'b0; cpu_addr_i = 32'h308;
      @(negedge clk); #1;
      n_cmp++;
      if (cpu_valid_o !== 1'b0 || cpu_stall_o !== 1'b0) begin
        n_fail++; $display("FAIL pz_idle_out p=%0d valid=%b stall=%b want 0 0", p, cpu_valid_o, cpu_stall_o);
      end
      if (p >= 1) begin
        n_cmp++;
        if (mem_ce_o !== 1'b0 || dbg_state !== 2'd0) begin
          n_fail++; $display("FAIL pz_idle_state p=%0d ce=%b state=%0d want 0 0", p, mem_ce_o, dbg_state);
        end
      end
    end
    // Resume: buffered word delivered at once, no issue while still idle.
    @(posedge clk); #1;
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h308;
    @(negedge clk); #1;
    n_cmp++;
    if (cpu_valid_o !== 1'b1 || cpu_inst_o !== mem_word(32'h308)) begin
      n_fail++; $display("FAIL pz_resume valid=%b inst=%h want 1 %h", cpu_valid_o, cpu_inst_o, mem_word(32'h308));
    end
    n_cmp++;
    if (mem_ce_o !== 1'b0 || mem_addr_o !== 32'h310) begin
      n_fail++; $display("FAIL pz_hold ce=%b addr=%h want 0 310", mem_ce_o, mem_addr_o);
    end
    @(posedge clk); #1;
    cpu_addr_i = 32'h30C;
    @(negedge clk); #1;
    n_cmp++;
    if (cpu_valid_o !== 1'b1 || cpu_inst_o !== mem_word(32'h30C)) begin
      n_fail++; $display("FAIL pz_second valid=%b inst=%h want 1 %h", cpu_valid_o, cpu_inst_o, mem_word(32'h30C));
    end
    n_cmp++;
    if (mem_ce_o !== 1'b1 || mem_addr_o !== 32'h314) begin
      n_fail++; $display("FAIL pz_reissue ce=%b addr=%h want 1 314", mem_ce_o, mem_addr_o);
    end
    run_stream(32'h310, 32'h320, 30, "pz_post");
  endtask

  // Reset asserted while the bridge is refilling.
  task automatic test_reset_refill;
    do_reset(5);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      cpu_ce_i = 1'b1; cpu_addr_i = 32'h500;
      @(negedge clk); #1;
    end
    n_cmp++;
    if (dbg_state !== 2'd1 || mem_ce_o !== 1'b1) begin
      n_fail++; $display("FAIL rr_refill state=%0d ce=%b want 1 1", dbg_state, mem_ce_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (cpu_valid_o !== 1'b0 || cpu_stall_o !== 1'b0 || cpu_inst_o !== 32'h0) begin
      n_fail++; $display("FAIL rr_cpu_out valid=%b stall=%b inst=%h want 0", cpu_valid_o, cpu_stall_o, cpu_inst_o);
    end
    n_cmp++;
    if (mem_ce_o !== 1'b0 || mem_addr_o !== 32'h0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL rr_mem_out ce=%b addr=%h state=%0d want 0", mem_ce_o, mem_addr_o, dbg_state);
    end
    do_reset(1);
    run_stream(32'h600, 32'h610, 20, "rr_post");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_credit();
    test_wrap();
    test_pause();
    test_reset_refill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
